// File: rtl/dac_pkg.sv
// Shared constants for the DAC write path.
// Serializer word layout and scheduler FSM encoding.
package dac_pkg;

  localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'h3;
  localparam int DAC_WORD_W = 24;
  localparam int DAC_SAMPLE_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT_BUSY = 2'd2;
  localparam state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr.
// Reusable by any controller sharing one resource among N requesters.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] c;

  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    c = '0;
    for (int k = 0; k < N; k++) begin
      c = IW'((int'(ptr) + k) % N);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/dac_channel_scheduler.sv
// Shares one DAC serializer among NUM_CH sample sources.
// Shadow + dirty per channel, round-robin drain, Ready-paced.
module dac_channel_scheduler
  import dac_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter logic [3:0] CMD = DAC_CMD_WRITE_UPDATE,
  parameter logic [3:0] ADDR_BASE = 4'h1,
  parameter int unsigned REFRESH_DIV = 48000,
  parameter int unsigned BUSY_TIMEOUT = 4,
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       Clock_48MHz,
  input  logic                       Reset,
  input  logic                       i_Enable,
  input  logic [NUM_CH-1:0]          i_Wr_Valid,
  input  logic [DAC_SAMPLE_W*NUM_CH-1:0] i_Wr_Data,
  input  logic                       i_DAC_Ready,
  output logic [DAC_WORD_W-1:0]      o_DAC_Data,
  output logic                       o_DAC_Send,
  output logic [NUM_CH-1:0]          o_Pending,
  output logic [7:0]                 o_Coalesced,
  output logic                       o_Busy
);

  state_t state, state_nx;

  logic [DAC_SAMPLE_W-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0] dirty, dirty_nx, clr, grant;
  logic [IW-1:0] ptr, win;
  logic any, go, wrap;
  logic [31:0] rcnt;
  logic [15:0] tmr;
  logic [7:0] coal;
  logic [8:0] coal_sum;
  logic [DAC_WORD_W-1:0] data;
  logic send;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req   (dirty),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign wrap = (REFRESH_DIV != 0) && (rcnt == REFRESH_DIV - 1);

  always_ff @(posedge Clock_48MHz) begin
    if (Reset) state <= ST_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (i_Enable && any && i_DAC_Ready)
          state_nx = ST_ISSUE;
      ST_ISSUE:
        state_nx = ST_WAIT_BUSY;
      ST_WAIT_BUSY:
        if (!i_DAC_Ready)
          state_nx = ST_WAIT_DONE;
        else if (tmr == 16'(BUSY_TIMEOUT - 1))
          state_nx = ST_IDLE;
      ST_WAIT_DONE:
        if (i_DAC_Ready)
          state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  // Dirty is dropped on the grant edge, so any write landing on or after
  // the latched word re-arms the channel and is sent on a later pass.
  always_comb begin
    go = (state == ST_IDLE) && (state_nx == ST_ISSUE);
    clr = go ? grant : '0;
    coal_sum = {1'b0, coal};
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_Wr_Valid[i] && dirty[i] && !clr[i])
        coal_sum = coal_sum + 9'd1;
      dirty_nx[i] = i_Wr_Valid[i] | wrap | (dirty[i] & ~clr[i]);
    end
  end

  always_ff @(posedge Clock_48MHz) begin
    if (Reset) begin
      dirty <= '0;
      ptr <= '0;
      rcnt <= '0;
      tmr <= '0;
      coal <= '0;
      data <= '0;
      send <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      dirty <= dirty_nx;
      coal <= (coal_sum > 9'd255) ? 8'd255 : coal_sum[7:0];
      if (REFRESH_DIV != 0) rcnt <= wrap ? '0 : rcnt + 32'd1;
      tmr <= (state == ST_WAIT_BUSY) ? tmr + 16'd1 : '0;
      send <= go;
      for (int i = 0; i < NUM_CH; i++)
        if (i_Wr_Valid[i])
          shadow[i] <= i_Wr_Data[DAC_SAMPLE_W*i +: DAC_SAMPLE_W];
      if (go) begin
        data <= {CMD, ADDR_BASE + 4'(win), shadow[win]};
        ptr <= (win == IW'(NUM_CH - 1)) ? '0 : IW'(win + 1'b1);
      end
    end
  end

  assign o_DAC_Data = data;
  assign o_DAC_Send = send;
  assign o_Pending = dirty;
  assign o_Coalesced = coal;
  assign o_Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed bench for dac_channel_scheduler with a Ready-pacing
// serializer model and a second instance exercising refresh.
module tb_dac_channel_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic [3:0] wv = '0;
  logic [63:0] wd = '0;
  logic rdy = 1'b1;
  logic [23:0] dd;
  logic ds;
  logic [3:0] pend;
  logic [7:0] coal;
  logic busy;

  logic [3:0] r_wv = '0;
  logic [63:0] r_wd = '0;
  logic r_rdy = 1'b1;
  logic [23:0] r_dd;
  logic r_ds;
  logic [3:0] r_pend;
  logic [7:0] r_coal;
  logic r_busy;

  dac_channel_scheduler dut (
    .Clock_48MHz (clk),
    .Reset       (rst),
    .i_Enable    (en),
    .i_Wr_Valid  (wv),
    .i_Wr_Data   (wd),
    .i_DAC_Ready (rdy),
    .o_DAC_Data  (dd),
    .o_DAC_Send  (ds),
    .o_Pending   (pend),
    .o_Coalesced (coal),
    .o_Busy      (busy)
  );

  dac_channel_scheduler #(.REFRESH_DIV(100)) dut_r (
    .Clock_48MHz (clk),
    .Reset       (rst),
    .i_Enable    (1'b1),
    .i_Wr_Valid  (r_wv),
    .i_Wr_Data   (r_wd),
    .i_DAC_Ready (r_rdy),
    .o_DAC_Data  (r_dd),
    .o_DAC_Send  (r_ds),
    .o_Pending   (r_pend),
    .o_Coalesced (r_coal),
    .o_Busy      (r_busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] d;
    int c;
  } snd_t;

  snd_t sq[$];
  snd_t rq[$];
  int ser_len = 0;
  int bcnt = 0;
  int viol = 0;
  int total = 0;
  int passed = 0;

  // Serializer model: Ready drops after a Send and stays low ser_len cycles.
  always @(negedge clk) begin
    if (ds) sq.push_back('{dd, cyc});
    if (r_ds) rq.push_back('{r_dd, cyc});
    if (rst) begin
      rdy = 1'b1;
      bcnt = 0;
    end else begin
      if (ds && !rdy) viol++;
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) rdy = 1'b1;
      end
      if (ds && ser_len > 0) begin
        bcnt = ser_len;
        rdy = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  function automatic logic [23:0] sd(input int i);
    return (i < sq.size()) ? sq[i].d : 24'hxxxxxx;
  endfunction

  function automatic logic [23:0] rd(input int i);
    return (i < rq.size()) ? rq[i].d : 24'hxxxxxx;
  endfunction

  task automatic do_reset(input int len);
    rst = 1'b1;
    wv = '0;
    r_wv = '0;
    en = 1'b1;
    step(2);
    rst = 1'b0;
    ser_len = len;
    sq.delete();
    rq.delete();
    viol = 0;
  endtask

  task automatic wr(input int ch, input logic [15:0] v);
    wv = '0;
    wv[ch] = 1'b1;
    wd[16*ch +: 16] = v;
    step(1);
    wv = '0;
  endtask

  typedef struct {
    int ch;
    logic [15:0] v;
    logic [23:0] exp;
  } vec_t;

  vec_t vt[4];
  int t0;

  initial begin
    vt[0] = '{2, 16'h1234, 24'h331234};
    vt[1] = '{0, 16'hABCD, 24'h31ABCD};
    vt[2] = '{3, 16'hFFFF, 24'h34FFFF};
    vt[3] = '{1, 16'h0000, 24'h320000};

    do_reset(0);
    check("rst_data", 32'(dd), 32'h0);
    check("rst_send", 32'(ds), 32'h0);
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_coal", 32'(coal), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 4; i++) begin
      do_reset(0);
      t0 = cyc;
      wr(vt[i].ch, vt[i].v);
      step(10);
      check("single_count", 32'(sq.size()), 32'd1);
      check("single_data", 32'(sd(0)), 32'(vt[i].exp));
      check("single_latency",
            (sq.size() > 0) ? 32'(sq[0].c - t0) : 32'hFFFF_FFFF, 32'd2);
      check("single_pend", 32'(pend), 32'h0);
      check("single_busy", 32'(busy), 32'h0);
    end

    do_reset(30);
    wv = 4'hF;
    wd = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    step(1);
    wv = '0;
    step(200);
    check("all4_count", 32'(sq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("all4_data", 32'(sd(i)),
            32'({4'h3, 4'(1 + i), 16'(16'h1000 + i)}));
    check("all4_no_send_busy", 32'(viol), 32'd0);
    check("all4_pend", 32'(pend), 32'h0);

    do_reset(30);
    wr(0, 16'h5555);
    step(4);
    check("coal_busy", 32'(busy), 32'd1);
    wr(1, 16'h0010);
    wr(1, 16'h0020);
    wr(1, 16'h0030);
    step(150);
    check("coal_count", 32'(sq.size()), 32'd2);
    check("coal_ch0", 32'(sd(0)), 32'h315555);
    check("coal_ch1", 32'(sd(1)), 32'h320030);
    check("coal_value", 32'(coal), 32'd2);

    do_reset(0);
    wr(2, 16'h1111);
    step(1);
    check("issue_send", 32'(ds), 32'd1);
    wr(2, 16'h2222);
    step(20);
    check("reissue_count", 32'(sq.size()), 32'd2);
    check("reissue_first", 32'(sd(0)), 32'h331111);
    check("reissue_second", 32'(sd(1)), 32'h332222);
    check("reissue_coal", 32'(coal), 32'd0);

    do_reset(0);
    r_wv = 4'hF;
    r_wd = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    step(1);
    r_wv = '0;
    step(49);
    rq.delete();
    step(300);
    check("refresh_count", 32'(rq.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      check("refresh_data", 32'(rd(i)),
            32'({4'h3, 4'(1 + i % 4), 16'(16'hA000 + i % 4)}));
    if (rq.size() >= 12) begin
      check("refresh_period1", 32'(rq[4].c - rq[0].c), 32'd100);
      check("refresh_period2", 32'(rq[8].c - rq[4].c), 32'd100);
    end else begin
      check("refresh_period", 32'(rq.size()), 32'd12);
    end
    check("refresh_coal", 32'(r_coal), 32'd0);

    do_reset(30);
    wr(1, 16'h7777);
    step(5);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sq.delete();
    check("midrst_data", 32'(dd), 32'h0);
    check("midrst_send", 32'(ds), 32'h0);
    check("midrst_pend", 32'(pend), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    step(50);
    check("midrst_nosend", 32'(sq.size()), 32'd0);

    do_reset(0);
    en = 1'b0;
    wr(0, 16'hBEEF);
    wr(3, 16'hCAFE);
    step(30);
    check("dis_nosend", 32'(sq.size()), 32'd0);
    check("dis_pend", 32'(pend), 32'h9);
    en = 1'b1;
    step(30);
    check("en_count", 32'(sq.size()), 32'd2);
    check("en_first", 32'(sd(0)), 32'h31BEEF);
    check("en_second", 32'(sd(1)), 32'h34CAFE);
    check("en_pend", 32'(pend), 32'h0);

    do_reset(0);
    en = 1'b0;
    for (int i = 0; i < 201; i++) wr(0, 16'(i));
    check("coal_200", 32'(coal), 32'd200);
    for (int i = 0; i < 59; i++) wr(0, 16'(i));
    check("coal_sat", 32'(coal), 32'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dac_channel_scheduler.md
Name: dac_channel_scheduler

Overview:
- Shares the single 24-bit DAC SPI serializer (i_Data/i_Send/o_Ready handshake) among NUM_CH independent sample sources.
- Holds a shadow register and dirty flag per channel, and picks dirty channels round-robin.
- Frames each write as {CMD, channel address, 16-bit sample}, and paces transfers against the serializer's Ready.
- Sits between the waveform/control logic and the DAC serializer in top.

Parameters:
- NUM_CH, 4, number of DAC channels (1..8).
- CMD, 4'h3, DAC command nibble (write-and-update) placed in bits [23:20].
- ADDR_BASE, 4'h1, address nibble of channel 0; channel i uses ADDR_BASE+i, mod 16.
- REFRESH_DIV, 48000, cycles between forced refreshes of all channels; 0 disables refresh.
- BUSY_TIMEOUT, 4, cycles allowed for Ready to fall after Send before the transfer is treated as complete.

Ports:
- Clock_48MHz  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- i_Enable  in  1  when low, no new transfers start; writes are still captured
- i_Wr_Valid  in  NUM_CH  per-channel write strobe, one cycle
- i_Wr_Data  in  16*NUM_CH  per-channel sample; channel i occupies [16i+15:16i]
- i_DAC_Ready  in  1  serializer idle
- o_DAC_Data  out  24  command word to serializer
- o_DAC_Send  out  1  one-cycle transfer strobe
- o_Pending  out  NUM_CH  dirty flags
- o_Coalesced  out  8  saturating count of writes that overwrote a still-dirty value
- o_Busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high, Clock_48MHz) clears the following:
  - all outputs to 0;
  - shadows to 0;
  - dirty flags to 0;
  - round-robin pointer to 0;
  - refresh counter to 0;
  - FSM to IDLE.
- Reset mid-transfer abandons the transfer with no further Send. The serializer is reset by the same signal.
- Capture: i_Wr_Valid[i] loads shadow[i] and sets dirty[i] on the next edge.
  - If dirty[i] was already set, and is not being cleared that same cycle, o_Coalesced increments; it saturates at 255.
- Refresh: a counter counts 0..REFRESH_DIV-1. On wrap it sets all dirty flags; this does not count as coalescing.
- Arbitration: the winner is the first dirty channel at or after ptr, with index wrap. After a grant, ptr becomes winner+1, mod NUM_CH.
- FSM states:
  - IDLE: if i_Enable, any dirty set, and i_DAC_Ready → ISSUE. The winner index is registered.
  - ISSUE (1 cycle):
    - o_DAC_Data <= {CMD, ADDR_BASE+idx, shadow[idx]};
    - o_DAC_Send <= 1;
    - dirty[idx] cleared → WAIT_BUSY.
    - A write to idx in this same cycle wins: dirty stays set and the new value is sent later.
  - WAIT_BUSY:
    - o_DAC_Send <= 0.
    - If Ready==0 → WAIT_DONE.
    - Otherwise, after BUSY_TIMEOUT cycles → IDLE.
  - WAIT_DONE: when Ready==1 → IDLE.
- Send is asserted exactly one cycle per transfer. o_DAC_Data is stable from the Send cycle until the next ISSUE.
- Latency: write to Send is 2 cycles minimum (capture edge, IDLE decision, ISSUE output), with the serializer idle and no competing channels.
- o_Busy = (state != IDLE).
- Deasserting i_Enable mid-transfer lets the current transfer finish; no new transfer is started.

Decomposition:
- Shared package dac_pkg holds:
  - DAC_CMD_WRITE_UPDATE = 4'h3;
  - DAC_WORD_W = 24;
  - DAC_SAMPLE_W = 16;
  - the FSM state encoding localparams.
- One sub-module: rr_arbiter (NUM_CH request vector plus pointer → one-hot/index grant, combinational) for reuse by other shared-resource controllers.

Test Plan:
- Single write ch2=16'h1234, Ready=1 → exactly one Send, Data=24'h331234, 2 cycles after the strobe; o_Pending returns to 0.
- Writes to all 4 channels in the same cycle, with a serializer model holding Ready low for 30 cycles per word → Sends in order ch0,1,2,3 with addresses 1..4; no Send while Ready is low.
- Three writes to ch1 (0x0010, 0x0020, 0x0030) while a ch0 transfer is busy → one ch1 Send with 0x0030; o_Coalesced=2.
- Write to the channel being issued, in the ISSUE cycle → that channel is sent twice, the second time with the new value.
- REFRESH_DIV=100, no writes → every 100 cycles, NUM_CH Sends carrying the current shadow values.
- Reset asserted in WAIT_DONE, and separately i_Enable=0 with pending writes → all outputs and flags 0 and no Send after reset; no Send until i_Enable rises, then pending channels drain.
